arith_seq_ctrl: RTL and testbench

Sequencer and two-way arbiter for a shared iterative arithmetic unit covering add, subtract, multiply, unsigned divide and rotate-right. Two requesters issue operations over valid/ready channels. The controller grants them round-robin, runs the selected operation on one multi-cycle datapath, and returns each result with the requester id on a single response channel. It is the only path to the shared arithmetic resource; one operation is in flight at a time.

---
 rtl/arith_seq_pkg.sv | 19 +
 rtl/arith_iter_core.sv | 140 ++++++++++++++
 rtl/arith_seq_chk.sv | 26 ++
 rtl/arith_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_arith_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_seq_pkg.sv
// Shared opcodes, controller state encoding and widths for the arithmetic
// sequencer and its iterative datapath.
package arith_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/arith_iter_core.sv
// Shared datapath: single-step add/sub/rotate, WIDTH-step shift-add multiply
// and restoring divide. done/data/flag describe the step running this cycle.
module arith_iter_core
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  logic                   active_r;
  logic [OP_W-1:0]        op_r;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic [WIDTH-1:0]       mplier_r;
  logic [WIDTH-1:0]       rem_r;
  logic [WIDTH-1:0]       quo_r;
  logic [2*WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [CW-1:0]          cnt_r;

  logic [2*WIDTH-1:0]     mul_acc_s;
  logic [WIDTH:0]         rem_shift_s;
  logic [WIDTH-1:0]       div_rem_s;
  logic                   q_bit_s;
  logic [WIDTH-1:0]       quo_next_s;
  logic [WIDTH:0]         sum_s;
  logic [WIDTH:0]         diff_s;
  logic                   div_zero_s;
  logic                   iterative_s;

  // One multiply / divide iteration plus the single-step arithmetic.
  always_comb begin
    mul_acc_s   = acc_r + (mplier_r[0] ? mcand_r : {2*WIDTH{1'b0}});
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    q_bit_s     = 1'b0;
    div_rem_s   = rem_shift_s[WIDTH-1:0];
    if (rem_shift_s >= {1'b0, b_r}) begin
      q_bit_s   = 1'b1;
      div_rem_s = rem_shift_s[WIDTH-1:0] - b_r;
    end else begin
      q_bit_s   = 1'b0;
      div_rem_s = rem_shift_s[WIDTH-1:0];
    end
    quo_next_s  = {quo_r[WIDTH-2:0], q_bit_s};
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    // The extra top bit of a widened subtraction is exactly the unsigned borrow.
    diff_s      = {1'b0, a_r} - {1'b0, b_r};
    div_zero_s  = (b_r == {WIDTH{1'b0}});
    iterative_s = (op_r == OP_MUL) || ((op_r == OP_DIV) && !div_zero_s);
  end

  // Completion and result selection for the current step.
  always_comb begin
    done = active_r && (!iterative_s || (cnt_r == LAST_STEP));
    data = {WIDTH{1'b0}};
    flag = 1'b0;
    case (op_r)
      OP_ADD: begin
        data = sum_s[WIDTH-1:0];
        flag = sum_s[WIDTH];
      end
      OP_SUB: begin
        data = diff_s[WIDTH-1:0];
        flag = diff_s[WIDTH];
      end
      OP_MUL: begin
        data = mul_acc_s[WIDTH-1:0];
        flag = |mul_acc_s[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (div_zero_s) begin
          data = {WIDTH{1'b1}};
          flag = 1'b1;
        end else begin
          data = quo_next_s;
          flag = 1'b0;
        end
      end
      OP_ROR: begin
        data = {a_r[0], a_r[WIDTH-1:1]};
        flag = 1'b0;
      end
      default: begin
        data = {WIDTH{1'b0}};
        flag = 1'b1;
      end
    endcase
  end

  // Operand capture on start, then one iteration per cycle until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      op_r     <= {OP_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      mcand_r  <= {2*WIDTH{1'b0}};
      acc_r    <= {2*WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      op_r     <= op;
      a_r      <= a;
      b_r      <= b;
      mplier_r <= b;
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= a;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= {2*WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (active_r) begin
      active_r <= ~done;
      acc_r    <= mul_acc_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      rem_r    <= div_rem_s;
      quo_r    <= quo_next_s;
      cnt_r    <= cnt_r + CNT_ONE;
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_seq_chk.sv
// Protocol properties of the sequencer's external channels.
module arith_seq_chk #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic [1:0]       req_ready,
  input logic             busy,
  input logic             rsp_valid,
  input logic             rsp_ready,
  input logic             rsp_id,
  input logic [WIDTH-1:0] rsp_data,
  input logic             rsp_flag
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (req_ready == 2'b00));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) &&
                                   $stable(rsp_id) && $stable(rsp_flag)));

endmodule

// File: rtl/arith_seq_ctrl.sv
// Two-requester round-robin sequencer in front of the shared iterative
// arithmetic core; one operation in flight, results returned with requester id.
module arith_seq_ctrl
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OP_W-1:0]  req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_flag,
  output logic               busy
);

  state_e state_r;
  state_e state_n;

  logic             rr_ptr_r;
  logic             id_r;
  logic             busy_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_flag_r;

  logic             gnt_id_s;
  logic [1:0]       ready_s;
  logic             accept_s;
  logic [OP_W-1:0]  sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             core_done_s;
  logic [WIDTH-1:0] core_data_s;
  logic             core_flag_s;

  // Arbitration: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    gnt_id_s = 1'b0;
    ready_s  = 2'b00;
    if (req_valid == 2'b11) begin
      gnt_id_s = rr_ptr_r;
    end else begin
      gnt_id_s = req_valid[1];
    end
    if ((state_r == ST_IDLE) && (req_valid != 2'b00)) begin
      ready_s = gnt_id_s ? 2'b10 : 2'b01;
    end else begin
      ready_s = 2'b00;
    end
    accept_s = |(ready_s & req_valid);
    sel_op_s = gnt_id_s ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
    sel_a_s  = gnt_id_s ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    sel_b_s  = gnt_id_s ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_n = ST_EXEC;
        else          state_n = ST_IDLE;
      end
      ST_EXEC: begin
        if (core_done_s) state_n = ST_RESP;
        else             state_n = ST_EXEC;
      end
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
        else           state_n = ST_RESP;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= 1'b0;
      id_r        <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= {WIDTH{1'b0}};
      rsp_flag_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      busy_r      <= (state_n != ST_IDLE);
      rsp_valid_r <= (state_n == ST_RESP);
      if (accept_s) begin
        id_r <= gnt_id_s;
      end
      if ((state_r == ST_EXEC) && core_done_s) begin
        rsp_id_r   <= id_r;
        rsp_data_r <= core_data_s;
        rsp_flag_r <= core_flag_s;
      end
      // The requester just served yields priority to the other one.
      if ((state_r == ST_RESP) && rsp_ready) begin
        rr_ptr_r <= ~rsp_id_r;
      end
    end
  end

  assign req_ready = ready_s;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_flag  = rsp_flag_r;

  arith_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept_s),
    .op    (sel_op_s),
    .a     (sel_a_s),
    .b     (sel_b_s),
    .done  (core_done_s),
    .data  (core_data_s),
    .flag  (core_flag_s)
  );

  arith_seq_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag)
  );

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl: a cycle-count reference model checked every
// cycle, plus hand-computed results for the key operations.
module tb_arith_seq_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [5:0]    req_op = 6'd0;
  logic [2*W-1:0] req_a = 32'd0;
  logic [2*W-1:0] req_b = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  logic          rsp_flag;
  logic          busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  arith_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference result {flag, data} straight from the operation definitions.
  function automatic logic [W:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b), W'(a - b)};
      3'd2: begin
        p = 32'(a) * 32'(b);
        return {(p[2*W-1:W] != 16'd0), p[W-1:0]};
      end
      3'd3: return (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, W'(a / b)};
      3'd4: return {1'b0, a[0], a[W-1:1]};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [W-1:0] b);
    return ((op == 3'd2) || ((op == 3'd3) && (b != 16'd0))) ? W : 1;
  endfunction

  // Model: phase 0 idle, 1 computing (m_left cycles to go), 2 response pending.
  int         m_phase = 0;
  int         m_left = 0;
  logic       m_rr = 1'b0;
  logic       m_id = 1'b0;
  logic [W:0] m_res = 17'd0;

  logic       nid;
  logic [2:0] nop;
  logic [W-1:0] na, nb;
  assign nid = (req_valid == 2'b11) ? m_rr : req_valid[1];
  assign nop = nid ? req_op[5:3] : req_op[2:0];
  assign na  = nid ? req_a[31:16] : req_a[15:0];
  assign nb  = nid ? req_b[31:16] : req_b[15:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_rr    <= 1'b0;
    end else if (m_phase == 0) begin
      if (req_valid != 2'b00) begin
        m_id    <= nid;
        m_res   <= model_result(nop, na, nb);
        m_left  <= model_latency(nop, nb);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_phase <= 2;
    end else if (rsp_ready) begin
      m_rr    <= ~m_id;
      m_phase <= 0;
    end
  end

  function automatic logic [1:0] exp_ready(input int ph, input logic [1:0] v, input logic g);
    if (ph != 0 || v == 2'b00) return 2'b00;
    return g ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin
    check("cyc_req_ready", {30'd0, req_ready}, {30'd0, exp_ready(m_phase, req_valid, nid)});
    check("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_phase == 2)});
    check("cyc_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    if (m_phase == 2) begin
      check("cyc_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      check("cyc_rsp_data", {16'd0, rsp_data}, {16'd0, m_res[W-1:0]});
      check("cyc_rsp_flag", {31'd0, rsp_flag}, {31'd0, m_res[W]});
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic got;
    int n;
    if (id) begin
      req_op[5:3] = op; req_a[31:16] = a; req_b[31:16] = b;
    end else begin
      req_op[2:0] = op; req_a[15:0] = a; req_b[15:0] = b;
    end
    req_valid[id] = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = req_ready[id];
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", {31'd0, got}, 32'd1);
    req_valid[id] = 1'b0;
  endtask

  // Counts edges from the call point until rsp_valid is seen; returns at that negedge.
  task automatic wait_rsp(input string nm, input int lat, input logic id,
                          input logic [W-1:0] d, input logic f);
    logic seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({nm, "_lat"}, n, lat);
    check({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    check({nm, "_data"}, {16'd0, rsp_data}, {16'd0, d});
    check({nm, "_flag"}, {31'd0, rsp_flag}, {31'd0, f});
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic id, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] d, input logic f);
    issue(id, op, a, b);
    wait_rsp(nm, lat, id, d, f);
    release_rsp();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({nm, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check({nm, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
    check({nm, "_rsp_flag"}, {31'd0, rsp_flag}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_req_ready"}, {30'd0, req_ready}, 32'd0);
  endtask

  initial begin
    logic [3:0] rr_exp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op("add_carry", 1'b0, 3'd0, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1);
    run_op("mul_ovf", 1'b1, 3'd2, 16'd300, 16'd300, 16, 16'h5F90, 1'b1);
    run_op("div", 1'b0, 3'd3, 16'd100, 16'd7, 16, 16'd14, 1'b0);
    run_op("div_zero", 1'b0, 3'd3, 16'd5, 16'd0, 1, 16'hFFFF, 1'b1);
    run_op("sub_borrow", 1'b1, 3'd1, 16'd5, 16'd7, 1, 16'hFFFE, 1'b1);
    run_op("sub", 1'b0, 3'd1, 16'h1234, 16'h0234, 1, 16'h1000, 1'b0);
    run_op("illegal", 1'b1, 3'd6, 16'h1234, 16'h5678, 1, 16'h0000, 1'b1);
    run_op("mul_fit", 1'b0, 3'd2, 16'h00FF, 16'h0101, 16, 16'hFFFF, 1'b0);
    run_op("div_big", 1'b1, 3'd3, 16'hFFFF, 16'h0003, 16, 16'h5555, 1'b0);
    run_op("ror", 1'b0, 3'd4, 16'h0003, 16'hAAAA, 1, 16'h8001, 1'b0);

    // Response back-pressure with a second request waiting.
    issue(1'b0, 3'd0, 16'h1234, 16'h0F0F);
    req_op[5:3] = 3'd1; req_a[31:16] = 16'd5; req_b[31:16] = 16'd7;
    req_valid[1] = 1'b1;
    wait_rsp("stall", 1, 1'b0, 16'h2143, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", {16'd0, rsp_data}, 32'h2143);
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_ready", {30'd0, req_ready}, 32'd0);
    end
    release_rsp();
    @(negedge clk);
    check("bubble_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp("after_stall", 1, 1'b1, 16'hFFFE, 1'b1);
    release_rsp();

    // Reset during multiply step 8.
    issue(1'b0, 3'd2, 16'd300, 16'd300);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post_reset_add", 1'b0, 3'd0, 16'd2, 16'd3, 1, 16'd5, 1'b0);

    // Both requesters valid straight out of reset: grants must alternate.
    rst_n = 1'b0;
    req_op = {3'd4, 3'd4};
    req_a = {16'h0001, 16'h0001};
    req_b = 32'd0;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_exp = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("rr", 2, rr_exp[k], 16'h8000, 1'b0);
      release_rsp();
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
